// File: rtl/battery_level_estimator.sv
// battery_level_estimator: averages ADC windows, maps them to a slew-limited 0..100 % level.
// Define SENSOR_FAULT_EN to add sticky stuck-sensor detection (FAULT_CNT all-0/all-1 samples).
module battery_level_estimator #(
    parameter int               ADC_W    = 10,
    parameter int               AVG_LOG2 = 3,
    parameter logic [ADC_W-1:0] V_EMPTY  = 10'd600,
    parameter logic [ADC_W-1:0] V_FULL   = 10'd840
`ifdef SENSOR_FAULT_EN
    , parameter int             FAULT_CNT = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             adc_ready,
    output logic [7:0]       battery_level,
    output logic [7:0]       voltage,
    output logic             level_valid,
    output logic             sensor_fault
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int NUM_W = ADC_W + 7;
    localparam int REM_W = NUM_W - 1;
    localparam logic [NUM_W-1:0] DEN = NUM_W'(V_FULL - V_EMPTY);
    localparam logic [1:0] ACC = 2'd0, CALC = 2'd1, DIV = 2'd2, UPD = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [2:0]          div_cnt_q, div_cnt_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [6:0]          low_q, low_d, quo_q, quo_d;
    logic                sat_q, sat_d, first_q, first_d;
    logic [7:0]          volt_q, volt_d, level_q, level_d, voltage_q, voltage_d;
    logic                level_valid_q, level_valid_d, adc_ready_q, adc_ready_d;
    logic                transfer, fault_hold;
    logic [ADC_W-1:0]    avg;
    logic [NUM_W-1:0]    num, trial;
    logic                ge;
    logic [7:0]          target;

    assign transfer      = adc_valid & adc_ready_q;
    assign adc_ready     = adc_ready_q;
    assign battery_level = level_q;
    assign voltage       = voltage_q;
    assign level_valid   = level_valid_q;

    always_comb begin
        avg    = ADC_W'(acc_q >> AVG_LOG2);
        num    = (avg <= V_EMPTY) ? '0 : NUM_W'(avg - V_EMPTY) * NUM_W'(100);
        trial  = {rem_q, low_q[6]};
        ge     = trial >= DEN;
        target = (sat_q || quo_q > 7'd100) ? 8'd100 : {1'b0, quo_q};
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        div_cnt_d     = div_cnt_q;
        rem_d         = rem_q;
        low_d         = low_q;
        quo_d         = quo_q;
        sat_d         = sat_q;
        volt_d        = volt_q;
        level_d       = level_q;
        voltage_d     = voltage_q;
        first_d       = first_q;
        level_valid_d = 1'b0;
        case (state_q)
            ACC: if (transfer) begin
                acc_d = acc_q + ACC_W'(adc_data);
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == '1) ? CALC : ACC;
            end
            CALC: begin
                rem_d     = REM_W'(num >> 7);
                low_d     = num[6:0];
                quo_d     = '0;
                sat_d     = avg >= V_FULL;
                volt_d    = avg[ADC_W-1 -: 8];
                acc_d     = '0;
                cnt_d     = '0;
                div_cnt_d = '0;
                state_d   = DIV;
            end
            DIV: begin
                rem_d     = REM_W'(ge ? trial - DEN : trial);
                low_d     = {low_q[5:0], 1'b0};
                quo_d     = {quo_q[5:0], ge};
                div_cnt_d = div_cnt_q + 3'd1;
                state_d   = (div_cnt_q == 3'd6) ? UPD : DIV;
            end
            default: begin
                if (!fault_hold) begin
                    level_d = first_q ? target :
                              (target > level_q) ? level_q + 8'd1 :
                              (target < level_q) ? level_q - 8'd1 : level_q;
                    voltage_d     = volt_q;
                    level_valid_d = 1'b1;
                    first_d       = 1'b0;
                end
                state_d = ACC;
            end
        endcase
        adc_ready_d = state_d == ACC;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ACC;
            acc_q         <= '0;
            cnt_q         <= '0;
            div_cnt_q     <= '0;
            rem_q         <= '0;
            low_q         <= '0;
            quo_q         <= '0;
            sat_q         <= 1'b0;
            volt_q        <= '0;
            level_q       <= '0;
            voltage_q     <= '0;
            first_q       <= 1'b1;
            level_valid_q <= 1'b0;
            adc_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            div_cnt_q     <= div_cnt_d;
            rem_q         <= rem_d;
            low_q         <= low_d;
            quo_q         <= quo_d;
            sat_q         <= sat_d;
            volt_q        <= volt_d;
            level_q       <= level_d;
            voltage_q     <= voltage_d;
            first_q       <= first_d;
            level_valid_q <= level_valid_d;
            adc_ready_q   <= adc_ready_d;
        end
    end

`ifdef SENSOR_FAULT_EN
    localparam int FC_W = $clog2(FAULT_CNT + 1);
    logic [FC_W-1:0] stuck_q, stuck_d;
    logic            fault_q, fault_d;
    always_comb begin
        stuck_d = !transfer ? stuck_q :
                  !(&adc_data || ~|adc_data) ? '0 :
                  (stuck_q == FC_W'(FAULT_CNT)) ? stuck_q : stuck_q + 1'b1;
        fault_d = fault_q | (stuck_d == FC_W'(FAULT_CNT));
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stuck_q <= '0;
            fault_q <= 1'b0;
        end else begin
            stuck_q <= stuck_d;
            fault_q <= fault_d;
        end
    end
    assign fault_hold   = fault_q;
    assign sensor_fault = fault_q;
`else
    assign fault_hold   = 1'b0;
    assign sensor_fault = 1'b0;
`endif
endmodule

// File: tb/tb_battery_level_estimator.sv
// tb_battery_level_estimator: directed windows with a queue-based scoreboard checking level, voltage and latency.
module tb_battery_level_estimator;
    logic       clk = 1'b0, reset_n = 1'b0, adc_valid = 1'b0;
    logic [9:0] adc_data = '0;
    logic       adc_ready, level_valid, sensor_fault;
    logic [7:0] battery_level, voltage;
    int         vecs = 0, errs = 0, cyc = 0;

    typedef struct {
        int lvl;
        int volt;
        int at;
    } exp_t;
    exp_t sb[$];

    battery_level_estimator dut (
        .clk(clk), .reset_n(reset_n), .adc_valid(adc_valid), .adc_data(adc_data),
        .adc_ready(adc_ready), .battery_level(battery_level), .voltage(voltage),
        .level_valid(level_valid), .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every level_valid pulse must match the oldest expected update.
    always @(negedge clk) begin
        exp_t e;
        if (level_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_pulse: got level_valid with level %0d at cycle %0d, expected none", battery_level, cyc);
            end else begin
                e = sb.pop_front();
                check("level", int'(battery_level), e.lvl);
                check("voltage", int'(voltage), e.volt);
                check("latency_cycle", cyc, e.at);
            end
        end
    end

    task automatic send(input logic [9:0] d, input int gap, output int ac);
        int w;
        w = 0;
        adc_valid = 1'b1;
        adc_data  = d;
        while (!adc_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!adc_ready) begin
            vecs++;
            errs++;
            $display("FAIL ready_timeout: adc_ready got 0, expected 1");
        end
        ac = cyc + 1;
        @(negedge clk);
        adc_valid = 1'b0;
        adc_data  = 10'h155;
        repeat (gap) @(negedge clk);
    endtask

    task automatic window(input logic [9:0] d, input int gap, input bit exp_pulse, input int lvl);
        int ac;
        exp_t e;
        for (int i = 0; i < 8; i++) send(d, gap, ac);
        if (exp_pulse) begin
            e.lvl  = lvl;
            e.volt = int'(d[9:2]);
            e.at   = ac + 9;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("pending_updates", sb.size(), 0);
    endtask

    task automatic do_reset(input int n);
        reset_n   = 1'b0;
        adc_valid = 1'b0;
        repeat (n) @(negedge clk);
        check("rst_level", int'(battery_level), 0);
        check("rst_voltage", int'(voltage), 0);
        check("rst_level_valid", int'(level_valid), 0);
        check("rst_sensor_fault", int'(sensor_fault), 0);
        check("rst_adc_ready", int'(adc_ready), 0);
        sb.delete();
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(adc_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1);
    end

    initial begin
        bit exp_fault;
`ifdef SENSOR_FAULT_EN
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        do_reset(4);
        window(10'd720, 0, 1'b1, 50);
        drain();
        for (int k = 51; k <= 100; k++) window(10'd840, 0, 1'b1, k);
        window(10'd840, 0, 1'b1, 100);
        window(10'd840, 2, 1'b1, 100);
        drain();

        do_reset(2);
        window(10'd500, 0, 1'b1, 0);
        drain();
        do_reset(2);
        window(10'd1023, 0, 1'b1, 100);
        drain();

        // Reset lands in the DIV phase: that update must never appear.
        window(10'd720, 1, 1'b0, 0);
        repeat (3) @(negedge clk);
        do_reset(2);
        window(10'd720, 1, 1'b1, 50);
        adc_valid = 1'b1;
        adc_data  = 10'd0;
        repeat (7) @(negedge clk);
        adc_valid = 1'b0;
        window(10'd720, 0, 1'b1, 50);
        drain();

        do_reset(2);
        window(10'd0, 0, 1'b1, 0);
        window(10'd0, 0, !exp_fault, 0);
        drain();
        repeat (15) @(negedge clk);
        check("sensor_fault", int'(sensor_fault), int'(exp_fault));
        check("fault_level", int'(battery_level), 0);
        check("fault_voltage", int'(voltage), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
